// File: rtl/avmm_resp_pkg.sv
// Shared types and constants for the Avalon-MM burst responder.
// Also provides the burst-length clamp used by both host ports.
package avmm_resp_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_STREAM
  } rd_state_t;

  typedef enum logic {
    WR_IDLE,
    WR_BURST
  } wr_state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Fibonacci feedback bits for x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] clamp_len(input logic [15:0] bc);
    return (bc == 16'd0) ? 16'd1 : bc;
  endfunction

endpackage

// File: rtl/resp_ram.sv
// Simple dual-port word RAM: one write port, one read-first read port.
// Registered read data, one cycle after the read enable.
module resp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/avmm_burst_responder.sv
// Avalon-MM burst memory: s0 read bursts (first data RD_LATENCY after accept, one burst outstanding),
// s1 write bursts (no stall by default); AVMM_RESP_WAIT_INJECT_EN adds LFSR-driven waitrequest stalls.
module avmm_burst_responder
  import avmm_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 2,
  parameter int MAX_BURST   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] avs_s0_address,
  input  logic        avs_s0_read,
  input  logic [15:0] avs_s0_burstcount,
  output logic [31:0] avs_s0_readdata,
  output logic        avs_s0_readdatavalid,
  output logic        avs_s0_waitrequest,
  input  logic [31:0] avs_s1_address,
  input  logic [31:0] avs_s1_writedata,
  input  logic        avs_s1_write,
  input  logic [15:0] avs_s1_burstcount,
  output logic        avs_s1_waitrequest,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          LSB       = $clog2(WORD_BYTES);
  localparam logic [15:0] MAX_BC    = 16'(MAX_BURST);
  localparam logic [15:0] WAIT_INIT = (RD_LATENCY >= 2) ? 16'(RD_LATENCY - 2) : 16'd0;

  function automatic logic bad_cmd(input logic [LSB-1:0] lo, input logic [15:0] bc);
    return (bc == 16'd0) || (bc > MAX_BC) || (lo != '0);
  endfunction

  logic [AW-1:0] w_s0_idx;
  logic [AW-1:0] w_s1_idx;
  logic          w_unused_addr_bits;

  assign w_s0_idx = avs_s0_address[LSB +: AW];
  assign w_s1_idx = avs_s1_address[LSB +: AW];
  assign w_unused_addr_bits = ^{avs_s0_address[31:LSB+AW], avs_s1_address[31:LSB+AW]};

  logic w_rd_stall;
  logic w_wr_stall;

`ifdef AVMM_RESP_WAIT_INJECT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_rd_stall = r_lfsr[0];
  assign w_wr_stall = r_lfsr[1];
`else
  assign w_rd_stall = 1'b0;
  assign w_wr_stall = 1'b0;
`endif

  // ---------------- read port ----------------
  rd_state_t     r_rd_state, w_rd_state_nxt;
  logic [15:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic [15:0]   r_rd_len;
  logic [AW-1:0] r_iss_idx;
  logic [15:0]   r_iss_left;
  logic          w_rd_acc;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_raddr;
  logic [31:0]   w_ram_q;
  logic [31:0]   w_rd_dat;

  assign avs_s0_waitrequest = (r_rd_state != RD_IDLE) | w_rd_stall;
  assign w_rd_acc           = avs_s0_read & ~avs_s0_waitrequest;

  // RAM reads are issued from the accept cycle onward so a same-cycle write is never seen;
  // the FSM below only times when the pipelined data is presented.
  assign w_ram_re    = w_rd_acc | (r_iss_left != '0);
  assign w_ram_raddr = w_rd_acc ? w_s0_idx : r_iss_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_left <= '0;
      r_iss_idx  <= '0;
      r_rd_len   <= 16'd1;
    end else if (w_rd_acc) begin
      r_iss_idx  <= w_s0_idx + AW'(1);
      r_iss_left <= clamp_len(avs_s0_burstcount) - 16'd1;
      r_rd_len   <= clamp_len(avs_s0_burstcount);
    end else if (r_iss_left != '0) begin
      r_iss_idx  <= r_iss_idx + AW'(1);
      r_iss_left <= r_iss_left - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= RD_IDLE;
      r_rd_cnt   <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_cnt_nxt   = r_rd_cnt;
    case (r_rd_state)
      RD_IDLE: begin
        if (w_rd_acc) begin
          if (RD_LATENCY == 1) begin
            w_rd_state_nxt = RD_STREAM;
            w_rd_cnt_nxt   = clamp_len(avs_s0_burstcount) - 16'd1;
          end else begin
            w_rd_state_nxt = RD_WAIT;
            w_rd_cnt_nxt   = WAIT_INIT;
          end
        end
      end
      RD_WAIT: begin
        if (r_rd_cnt == '0) begin
          w_rd_state_nxt = RD_STREAM;
          w_rd_cnt_nxt   = r_rd_len - 16'd1;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt - 16'd1;
        end
      end
      RD_STREAM: begin
        if (r_rd_cnt == '0) w_rd_state_nxt = RD_IDLE;
        else                w_rd_cnt_nxt   = r_rd_cnt - 16'd1;
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // The RAM register is the first latency stage; the rest is a plain data shift line.
  generate
    if (RD_LATENCY > 1) begin : g_pipe
      logic [31:0] r_dpipe [RD_LATENCY-1];

      always_ff @(posedge clk) begin
        r_dpipe[0] <= w_ram_q;
        for (int i = 1; i < RD_LATENCY - 1; i++) r_dpipe[i] <= r_dpipe[i-1];
      end

      assign w_rd_dat = r_dpipe[RD_LATENCY-2];
    end else begin : g_nopipe
      assign w_rd_dat = w_ram_q;
    end
  endgenerate

  assign avs_s0_readdatavalid = (r_rd_state == RD_STREAM);
  assign avs_s0_readdata      = avs_s0_readdatavalid ? w_rd_dat : '0;

  // ---------------- write port ----------------
  wr_state_t     r_wr_state, w_wr_state_nxt;
  logic [15:0]   r_wr_left, w_wr_left_nxt;
  logic [AW-1:0] r_wr_idx, w_wr_idx_nxt;
  logic          w_wr_beat;
  logic [AW-1:0] w_ram_waddr;

  assign avs_s1_waitrequest = w_wr_stall;
  assign w_wr_beat          = avs_s1_write & ~avs_s1_waitrequest;
  assign w_ram_waddr        = (r_wr_state == WR_IDLE) ? w_s1_idx : r_wr_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= WR_IDLE;
      r_wr_left  <= '0;
      r_wr_idx   <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_left  <= w_wr_left_nxt;
      r_wr_idx   <= w_wr_idx_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_left_nxt  = r_wr_left;
    w_wr_idx_nxt   = r_wr_idx;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_wr_beat) begin
          w_wr_left_nxt = clamp_len(avs_s1_burstcount) - 16'd1;
          w_wr_idx_nxt  = w_s1_idx + AW'(1);
          if (clamp_len(avs_s1_burstcount) != 16'd1) w_wr_state_nxt = WR_BURST;
        end
      end
      WR_BURST: begin
        if (w_wr_beat) begin
          w_wr_left_nxt = r_wr_left - 16'd1;
          w_wr_idx_nxt  = r_wr_idx + AW'(1);
          if (r_wr_left == 16'd1) w_wr_state_nxt = WR_IDLE;
        end
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  resp_ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_beat),
    .i_waddr (w_ram_waddr),
    .i_wdata (avs_s1_writedata),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q)
  );

  // ---------------- sticky error ----------------
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((w_rd_acc && bad_cmd(avs_s0_address[LSB-1:0], avs_s0_burstcount)) ||
                 (w_wr_beat && (r_wr_state == WR_IDLE) &&
                  bad_cmd(avs_s1_address[LSB-1:0], avs_s1_burstcount))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_avmm_burst_responder.sv
// Scoreboard bench for avmm_burst_responder: random and directed bursts against an array memory model.
module tb_avmm_burst_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int MAXB  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] avs_s0_address;
  logic        avs_s0_read;
  logic [15:0] avs_s0_burstcount;
  logic [31:0] avs_s0_readdata;
  logic        avs_s0_readdatavalid;
  logic        avs_s0_waitrequest;
  logic [31:0] avs_s1_address;
  logic [31:0] avs_s1_writedata;
  logic        avs_s1_write;
  logic [15:0] avs_s1_burstcount;
  logic        avs_s1_waitrequest;
  logic        err;

  avmm_burst_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT), .MAX_BURST(MAXB)) dut (
    .clk                  (clk),
    .reset                (reset),
    .avs_s0_address       (avs_s0_address),
    .avs_s0_read          (avs_s0_read),
    .avs_s0_burstcount    (avs_s0_burstcount),
    .avs_s0_readdata      (avs_s0_readdata),
    .avs_s0_readdatavalid (avs_s0_readdatavalid),
    .avs_s0_waitrequest   (avs_s0_waitrequest),
    .avs_s1_address       (avs_s1_address),
    .avs_s1_writedata     (avs_s1_writedata),
    .avs_s1_write         (avs_s1_write),
    .avs_s1_burstcount    (avs_s1_burstcount),
    .avs_s1_waitrequest   (avs_s1_waitrequest),
    .err                  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];
  logic [31:0] dq[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_beats = 0;
  int          s0_stalls = 0;
  int          s1_stalls = 0;
  logic        exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic bad(input logic [31:0] a, input logic [15:0] bc);
    return (bc == 16'd0) || (bc > 16'(MAXB)) || (a[1:0] != 2'b00);
  endfunction

  function automatic int widx(input logic [31:0] a, input int beat);
    return int'(((a >> 2) + 32'(beat)) % DEPTH);
  endfunction

  // Monitor: every readdatavalid beat must match the next scoreboard entry in data and cycle.
  always @(negedge clk) begin
    if (reset === 1'b0 && avs_s0_readdatavalid === 1'b1) begin
      n_beats++;
      chk("rdv_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("rd_data", avs_s0_readdata, mon_e.d);
        chk("rd_cycle", 32'(cyc), 32'(mon_e.at));
        chk("s0_wait_in_burst", 32'(avs_s0_waitrequest), 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: %0d beats outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [15:0] bc);
    int t = 0;
    int len;
    wait_idle();
    avs_s0_address    = a;
    avs_s0_burstcount = bc;
    avs_s0_read       = 1'b1;
    while (avs_s0_waitrequest && t < 200) begin
      s0_stalls++;
      @(posedge clk);
      #1;
      t++;
    end
    if (avs_s0_waitrequest) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rd_accept_timeout: waitrequest %b, expected 0", avs_s0_waitrequest);
      avs_s0_read = 1'b0;
      return;
    end
    len = (bc == 16'd0) ? 1 : int'(bc);
    for (int i = 0; i < len; i++) sbq.push_back('{d: model[widx(a, i)], at: cyc + LAT + i});
    if (bad(a, bc)) exp_err = 1'b1;
    @(posedge clk);
    #1;
    avs_s0_read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] bc, input logic [31:0] d[$],
                    input int gap_at, input int gap_len);
    int len = (bc == 16'd0) ? 1 : int'(bc);
    int t;
    for (int b = 0; b < len; b++) begin
      if (b == gap_at) begin
        avs_s1_write = 1'b0;
        repeat (gap_len) begin
          @(posedge clk);
          #1;
        end
      end
      avs_s1_address    = (b == 0) ? a : $urandom;
      avs_s1_burstcount = (b == 0) ? bc : 16'($urandom);
      avs_s1_writedata  = d[b];
      avs_s1_write      = 1'b1;
      t = 0;
      while (avs_s1_waitrequest && t < 200) begin
        s1_stalls++;
        @(posedge clk);
        #1;
        t++;
      end
      if (avs_s1_waitrequest) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wr_beat_timeout: waitrequest %b, expected 0", avs_s1_waitrequest);
        avs_s1_write = 1'b0;
        return;
      end
      model[widx(a, b)] = d[b];
      @(posedge clk);
      #1;
    end
    avs_s1_write = 1'b0;
    if (bad(a, bc)) exp_err = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset        = 1'b1;
    avs_s0_read  = 1'b0;
    avs_s1_write = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_err = 1'b0;
    sbq.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base;
    int nb;
    logic [15:0] bc;
    reset             = 1'b1;
    avs_s0_address    = '0;
    avs_s0_read       = 1'b0;
    avs_s0_burstcount = '0;
    avs_s1_address    = '0;
    avs_s1_writedata  = '0;
    avs_s1_write      = 1'b0;
    avs_s1_burstcount = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdv", 32'(avs_s0_readdatavalid), 32'd0);
    chk("rst_readdata", avs_s0_readdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifndef AVMM_RESP_WAIT_INJECT_EN
    chk("rst_s0_wait", 32'(avs_s0_waitrequest), 32'd0);
    chk("rst_s1_wait", 32'(avs_s1_waitrequest), 32'd0);
`endif
    @(posedge clk);
    #1;

    // single write then read
    dq = {32'hDEADBEEF};
    wr(32'h40, 16'd1, dq, -1, 0);
    rd(32'h40, 16'd1);
    wait_idle();
    chk("err_single", 32'(err), 32'(exp_err));

    // burst of 4 with a two-cycle gap after beat 2
    dq = {32'd1, 32'd2, 32'd3, 32'd4};
    wr(32'h100, 16'd4, dq, 2, 2);
    rd(32'h100, 16'd4);
    wait_idle();
`ifndef AVMM_RESP_WAIT_INJECT_EN
    chk("s0_wait_after_burst", 32'(avs_s0_waitrequest), 32'd0);
`endif

    // wrap-around from the last word
    dq = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    wr(32'hFFC, 16'd3, dq, -1, 0);
    rd(32'hFFC, 16'd3);
    rd(32'h0, 16'd1);
    rd(32'h1004, 16'd1);

    // same-cycle write and read of word 5
    dq = {32'h11};
    wr(32'h14, 16'd1, dq, -1, 0);
    wait_idle();
    t = 0;
    while ((avs_s0_waitrequest || avs_s1_waitrequest) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("collide_ports_free", 32'(avs_s0_waitrequest | avs_s1_waitrequest), 32'd0);
    avs_s0_address    = 32'h14;
    avs_s0_burstcount = 16'd1;
    avs_s0_read       = 1'b1;
    avs_s1_address    = 32'h14;
    avs_s1_burstcount = 16'd1;
    avs_s1_writedata  = 32'h22;
    avs_s1_write      = 1'b1;
    sbq.push_back('{d: model[5], at: cyc + LAT});
    model[5] = 32'h22;
    @(posedge clk);
    #1;
    avs_s0_read  = 1'b0;
    avs_s1_write = 1'b0;
    rd(32'h14, 16'd1);
    wait_idle();
    chk("err_before_bc0", 32'(err), 32'(exp_err));

    // burstcount 0 -> one beat, err set
    rd(32'h40, 16'd0);
    wait_idle();
    chk("err_bc0", 32'(err), 32'(exp_err));

    // reset during a read burst of 8
    dq = {};
    for (int i = 0; i < 8; i++) dq.push_back($urandom);
    wr(32'h300, 16'd8, dq, -1, 0);
    base = n_beats;
    rd(32'h300, 16'd8);
    t = 0;
    while (n_beats < base + 3 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("beats_before_reset", 32'(n_beats - base), 32'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_err = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("postrst_rdv", 32'(avs_s0_readdatavalid), 32'd0);
    chk("postrst_err", 32'(err), 32'd0);
`ifndef AVMM_RESP_WAIT_INJECT_EN
    chk("postrst_s0_wait", 32'(avs_s0_waitrequest), 32'd0);
`endif
    repeat (8) @(negedge clk);
    chk("no_beats_after_reset", 32'(n_beats - base), 32'd3);
    @(posedge clk);
    #1;
    rd(32'h300, 16'd8);

    // misaligned first-beat address: low bits ignored, err set
    dq = {32'h5A5A_5A5A};
    wr(32'h202, 16'd1, dq, -1, 0);
    rd(32'h200, 16'd1);
    wait_idle();
    chk("err_misaligned", 32'(err), 32'(exp_err));

    // oversize bursts still run their full count
    do_reset();
    dq = {};
    for (int i = 0; i < 66; i++) dq.push_back($urandom);
    wr(32'h800, 16'd66, dq, 10, 1);
    rd(32'h800, 16'd66);
    wait_idle();
    chk("err_oversize", 32'(err), 32'(exp_err));

    // random phase: fill, 1000 random write beats, random reads
    do_reset();
    for (int k = 0; k < 16; k++) begin
      dq = {};
      for (int i = 0; i < 64; i++) dq.push_back($urandom);
      wr(32'(k * 256), 16'd64, dq, int'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
    end
    nb = 0;
    while (nb < 1000) begin
      bc = 16'($urandom_range(1, 8));
      dq = {};
      for (int i = 0; i < int'(bc); i++) dq.push_back($urandom);
      wr($urandom & ~32'h3, bc, dq, int'($urandom_range(0, 8)), int'($urandom_range(0, 2)));
      nb += int'(bc);
    end
    repeat (150) rd($urandom & ~32'h3, 16'($urandom_range(1, 16)));
    wait_idle();
    chk("err_random", 32'(err), 32'(exp_err));
`ifdef AVMM_RESP_WAIT_INJECT_EN
    chk("s0_stall_seen", 32'(s0_stalls > 0), 32'd1);
    chk("s1_stall_seen", 32'(s1_stalls > 0), 32'd1);
`else
    chk("s0_no_idle_stall", 32'(s0_stalls), 32'd0);
    chk("s1_no_stall", 32'(s1_stalls), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
